// File: rtl/alu_cmd_sequencer_pkg.sv
// alu_pkg: shared definitions for the ALU command sequencer slice.
//   ALU_W         datapath width of the 8-bit ALU
//   OP_ADD..OP_NOT ALU_Sel encodings; 101..111 are illegal
//   state_t       sequencer FSM states
//   op_legal()    true for the five implemented opcodes
package alu_pkg;

   localparam int ALU_W = 8;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_NOT = 3'b100;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      RESP  = 2'd2
   } state_t;

   function automatic logic op_legal(input logic [2:0] op);
      return (op <= OP_NOT);
   endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if: command and response handshake bundle between a
// host (master) and the ALU command sequencer (slave).
//   cmd_valid/cmd_ready  command handshake
//   cmd_op/a/b/acc       command payload
//   rsp_valid/rsp_ready  response handshake
//   rsp_data/carry/err   response payload
interface alu_cmd_sequencer_if;

   logic                       cmd_valid;
   logic                       cmd_ready;
   logic [2:0]                 cmd_op;
   logic [alu_pkg::ALU_W-1:0]  cmd_a;
   logic [alu_pkg::ALU_W-1:0]  cmd_b;
   logic                       cmd_acc;
   logic                       rsp_valid;
   logic                       rsp_ready;
   logic [alu_pkg::ALU_W-1:0]  rsp_data;
   logic                       rsp_carry;
   logic                       rsp_err;

   modport master (
      output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_acc, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_acc, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_err
   );

endinterface

// File: rtl/alu.sv
// alu: 8-bit combinational ALU driven by the sequencer.
//   A, B      operands
//   ALU_Sel   operation (add, sub, and, or, not A); others yield 0
//   ALU_Out   result
//   CarryOut  add carry / sub borrow, 0 for logic ops
module alu
   import alu_pkg::*;
(
   input  logic [ALU_W-1:0] A,
   input  logic [ALU_W-1:0] B,
   input  logic [2:0]       ALU_Sel,
   output logic [ALU_W-1:0] ALU_Out,
   output logic             CarryOut
);

   logic [ALU_W:0] w_res;

   always_comb begin
      w_res = '0;
      case (ALU_Sel)
         OP_ADD:  w_res = {1'b0, A} + {1'b0, B};
         OP_SUB:  w_res = {1'b0, A} - {1'b0, B};
         OP_AND:  w_res = {1'b0, A & B};
         OP_OR:   w_res = {1'b0, A | B};
         OP_NOT:  w_res = {1'b0, ~A};
         default: w_res = '0;
      endcase
   end

   assign ALU_Out  = w_res[ALU_W-1:0];
   assign CarryOut = w_res[ALU_W];

endmodule

// File: rtl/alu_cmd_sequencer_ref_model.sv
// alu_ref_model: combinational expected {carry,out} for the latched ALU
// operands, used to cross-check the real ALU at capture time.
//   i_a, i_b, i_sel   latched operands and opcode
//   o_out, o_carry    expected result and carry/borrow
module alu_ref_model
   import alu_pkg::*;
(
   input  logic [ALU_W-1:0] i_a,
   input  logic [ALU_W-1:0] i_b,
   input  logic [2:0]       i_sel,
   output logic [ALU_W-1:0] o_out,
   output logic             o_carry
);

   logic [ALU_W:0] w_exp;

   always_comb begin
      w_exp = '0;
      case (i_sel)
         OP_ADD:  w_exp = {1'b0, i_a} + {1'b0, i_b};
         OP_SUB:  w_exp = {1'b0, i_a} - {1'b0, i_b};
         OP_AND:  w_exp = {1'b0, i_a & i_b};
         OP_OR:   w_exp = {1'b0, i_a | i_b};
         OP_NOT:  w_exp = {1'b0, ~i_a};
         default: w_exp = '0;
      endcase
   end

   assign o_out   = w_exp[ALU_W-1:0];
   assign o_carry = w_exp[ALU_W];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: accepts ALU commands, drives the ALU from registers,
// waits SETTLE_CYCLES (1..15), captures the result and returns it.
// Keeps an accumulator for chained commands and a completed-op counter.
//   clk, rst          clock, synchronous active-high reset
//   bus (slave)       command / response handshakes
//   alu_a/b/sel       registered ALU drive
//   alu_out/carry     ALU result
//   acc_q, op_count   accumulator, completed legal operations
//   chk_mismatch      sticky reference-model miscompare (ALU_SEQ_CHECK_EN only)
//
// state | meaning
// IDLE  | cmd_ready=1, waiting for a command
// DRIVE | operands held on ALU, settle counter running
// RESP  | response presented until rsp_ready
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   alu_cmd_sequencer_if.slave   bus,
   output logic [ALU_W-1:0]     alu_a,
   output logic [ALU_W-1:0]     alu_b,
   output logic [2:0]           alu_sel,
   input  logic [ALU_W-1:0]     alu_out,
   input  logic                 alu_carry,
   output logic [ALU_W-1:0]     acc_q,
   output logic [15:0]          op_count
`ifdef ALU_SEQ_CHECK_EN
  ,output logic                 chk_mismatch
`endif
);

   localparam logic [3:0] LP_CNT_LOAD = 4'(SETTLE_CYCLES - 1);

   state_t           r_state, w_next;
   logic [3:0]       r_cnt;
   logic [ALU_W-1:0] r_alu_a, r_alu_b, r_acc, r_rsp_data;
   logic [2:0]       r_alu_sel;
   logic             r_rsp_carry, r_rsp_err;
   logic [15:0]      r_op_count;
   logic             w_accept, w_illegal, w_capture, w_rsp_done;
   logic             w_cmd_ready, w_rsp_valid;

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_accept    = 1'b0;
      w_illegal   = 1'b0;
      w_capture   = 1'b0;
      w_rsp_done  = 1'b0;
      w_cmd_ready = 1'b0;
      w_rsp_valid = 1'b0;
      case (r_state)
         IDLE: begin
            w_cmd_ready = 1'b1;
            if (bus.cmd_valid) begin
               if (op_legal(bus.cmd_op)) begin
                  w_accept = 1'b1;
                  w_next   = DRIVE;
               end else begin
                  w_illegal = 1'b1;
                  w_next    = RESP;
               end
            end
         end
         DRIVE: begin
            if (r_cnt == 4'd0) begin
               w_capture = 1'b1;
               w_next    = RESP;
            end
         end
         RESP: begin
            w_rsp_valid = 1'b1;
            if (bus.rsp_ready) begin
               w_rsp_done = 1'b1;
               w_next     = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_sel   <= '0;
         r_cnt       <= '0;
         r_acc       <= '0;
         r_rsp_data  <= '0;
         r_rsp_carry <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_op_count  <= '0;
      end else begin
         if (w_accept) begin
            r_alu_a   <= bus.cmd_acc ? r_acc : bus.cmd_a;
            r_alu_b   <= bus.cmd_b;
            r_alu_sel <= bus.cmd_op;
            r_cnt     <= LP_CNT_LOAD;
         end else if (r_state == DRIVE && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_capture) begin
            r_rsp_data  <= alu_out;
            r_rsp_carry <= alu_carry;
            r_rsp_err   <= 1'b0;
            r_acc       <= alu_out;
         end
         if (w_illegal) begin
            r_rsp_data  <= '0;
            r_rsp_carry <= 1'b0;
            r_rsp_err   <= 1'b1;
         end
         if (w_rsp_done && !r_rsp_err) r_op_count <= r_op_count + 16'd1;
      end
   end

`ifdef ALU_SEQ_CHECK_EN
   logic [ALU_W-1:0] w_exp_out;
   logic             w_exp_carry;
   logic             r_chk;

   alu_ref_model u_ref (
      .i_a     (r_alu_a),
      .i_b     (r_alu_b),
      .i_sel   (r_alu_sel),
      .o_out   (w_exp_out),
      .o_carry (w_exp_carry)
   );

   always_ff @(posedge clk) begin
      if (rst)
         r_chk <= 1'b0;
      else if (w_capture && ({alu_carry, alu_out} != {w_exp_carry, w_exp_out}))
         r_chk <= 1'b1;
   end

   assign chk_mismatch = r_chk;
`endif

   // Handshake outputs are forced low while rst is held so nothing is
   // offered or accepted during reset.
   assign bus.cmd_ready = w_cmd_ready & ~rst;
   assign bus.rsp_valid = w_rsp_valid & ~rst;
   assign bus.rsp_data  = r_rsp_data;
   assign bus.rsp_carry = r_rsp_carry;
   assign bus.rsp_err   = r_rsp_err;
   assign alu_a         = r_alu_a;
   assign alu_b         = r_alu_b;
   assign alu_sel       = r_alu_sel;
   assign acc_q         = r_acc;
   assign op_count      = r_op_count;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench: u_dut1 (SETTLE_CYCLES=1) and u_dut4 (SETTLE_CYCLES=4),
// each wired to its own alu instance.
module tb_alu_cmd_sequencer;

   logic clk = 1'b0;
   logic rst1, rst4;
   logic force_zero;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   alu_cmd_sequencer_if bus1 ();
   alu_cmd_sequencer_if bus4 ();

   logic [7:0]  a1, b1, ao1_alu, ao1, acc1;
   logic [2:0]  s1;
   logic        c1;
   logic [15:0] cnt1;
   logic [7:0]  a4, b4, ao4, acc4;
   logic [2:0]  s4;
   logic        c4;
   logic [15:0] cnt4;
`ifdef ALU_SEQ_CHECK_EN
   logic chk1, chk4;
`endif

   alu u_alu1 (.A(a1), .B(b1), .ALU_Sel(s1), .ALU_Out(ao1_alu), .CarryOut(c1));
   assign ao1 = force_zero ? 8'h00 : ao1_alu;

   alu_cmd_sequencer #(.SETTLE_CYCLES(1)) u_dut1 (
      .clk(clk), .rst(rst1), .bus(bus1),
      .alu_a(a1), .alu_b(b1), .alu_sel(s1),
      .alu_out(ao1), .alu_carry(c1),
      .acc_q(acc1), .op_count(cnt1)
`ifdef ALU_SEQ_CHECK_EN
     ,.chk_mismatch(chk1)
`endif
   );

   alu u_alu4 (.A(a4), .B(b4), .ALU_Sel(s4), .ALU_Out(ao4), .CarryOut(c4));

   alu_cmd_sequencer #(.SETTLE_CYCLES(4)) u_dut4 (
      .clk(clk), .rst(rst4), .bus(bus4),
      .alu_a(a4), .alu_b(b4), .alu_sel(s4),
      .alu_out(ao4), .alu_carry(c4),
      .acc_q(acc4), .op_count(cnt4)
`ifdef ALU_SEQ_CHECK_EN
     ,.chk_mismatch(chk4)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a command on bus1, wait for accept, then count cycles from
   // the accept edge until rsp_valid (1 = visible right after accept).
   task automatic send1(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic acc, output int lat);
      int g;
      bus1.cmd_op    = op;
      bus1.cmd_a     = a;
      bus1.cmd_b     = b;
      bus1.cmd_acc   = acc;
      bus1.cmd_valid = 1'b1;
      g = 0;
      while (!bus1.cmd_ready && g < 20) begin
         tick();
         g++;
      end
      tick();
      bus1.cmd_valid = 1'b0;
      lat = 1;
      while (!bus1.rsp_valid && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic send4(input logic [7:0] a, input logic [7:0] b, output int lat);
      int g;
      bus4.cmd_op    = 3'b000;
      bus4.cmd_a     = a;
      bus4.cmd_b     = b;
      bus4.cmd_acc   = 1'b0;
      bus4.cmd_valid = 1'b1;
      g = 0;
      while (!bus4.cmd_ready && g < 20) begin
         tick();
         g++;
      end
      tick();
      bus4.cmd_valid = 1'b0;
      lat = 1;
      while (!bus4.rsp_valid && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   initial begin
      int  lat;
      logic seen;
      force_zero     = 1'b0;
      rst1           = 1'b1;
      rst4           = 1'b1;
      bus1.cmd_valid = 1'b0;
      bus1.cmd_op    = 3'b000;
      bus1.cmd_a     = 8'h00;
      bus1.cmd_b     = 8'h00;
      bus1.cmd_acc   = 1'b0;
      bus1.rsp_ready = 1'b1;
      bus4.cmd_valid = 1'b0;
      bus4.cmd_op    = 3'b000;
      bus4.cmd_a     = 8'h00;
      bus4.cmd_b     = 8'h00;
      bus4.cmd_acc   = 1'b0;
      bus4.rsp_ready = 1'b1;
      tick();
      tick();

      // reset state
      chk("rst_cmd_ready", 32'(bus1.cmd_ready), 32'h0);
      chk("rst_rsp_valid", 32'(bus1.rsp_valid), 32'h0);
      chk("rst_alu_a",     32'(a1),             32'h0);
      chk("rst_acc",       32'(acc1),           32'h0);
      chk("rst_op_count",  32'(cnt1),           32'h0);
      chk("rst_rsp_err",   32'(bus1.rsp_err),   32'h0);
`ifdef ALU_SEQ_CHECK_EN
      chk("rst_chk",       32'(chk1),           32'h0);
`endif
      rst1 = 1'b0;
      rst4 = 1'b0;
      tick();
      chk("post_rst_ready", 32'(bus1.cmd_ready), 32'h1);

      // add 01+09
      send1(3'b000, 8'h01, 8'h09, 1'b0, lat);
      chk("add_latency", 32'(lat),             32'd2);
      chk("add_data",    32'(bus1.rsp_data),   32'h0A);
      chk("add_carry",   32'(bus1.rsp_carry),  32'h0);
      chk("add_err",     32'(bus1.rsp_err),    32'h0);
      chk("add_alu_b",   32'(b1),              32'h09);
      chk("add_ready",   32'(bus1.cmd_ready),  32'h0);
      tick();
      chk("add_count",   32'(cnt1),            32'd1);
      chk("add_acc",     32'(acc1),            32'h0A);
      chk("add_rdy_back",32'(bus1.cmd_ready),  32'h1);
      chk("add_vld_low", 32'(bus1.rsp_valid),  32'h0);

      // sub with borrow
      send1(3'b001, 8'h02, 8'h0A, 1'b0, lat);
      chk("sub_data",  32'(bus1.rsp_data),  32'hF8);
      chk("sub_carry", 32'(bus1.rsp_carry), 32'h1);
      tick();

      // chain on accumulator: F8 & 0F, cmd_a ignored
      send1(3'b010, 8'h55, 8'h0F, 1'b1, lat);
      chk("and_alu_a", 32'(a1),             32'hF8);
      chk("and_data",  32'(bus1.rsp_data),  32'h08);
      chk("and_carry", 32'(bus1.rsp_carry), 32'h0);
      tick();
      chk("and_acc",   32'(acc1),           32'h08);
      chk("and_count", 32'(cnt1),           32'd3);

      // illegal opcode 110
      send1(3'b110, 8'h33, 8'h44, 1'b0, lat);
      chk("ill_latency", 32'(lat),            32'd1);
      chk("ill_err",     32'(bus1.rsp_err),   32'h1);
      chk("ill_data",    32'(bus1.rsp_data),  32'h00);
      chk("ill_carry",   32'(bus1.rsp_carry), 32'h0);
      chk("ill_alu_a",   32'(a1),             32'hF8);
      chk("ill_alu_sel", 32'(s1),             32'h2);
      tick();
      chk("ill_acc",     32'(acc1),           32'h08);
      chk("ill_count",   32'(cnt1),           32'd3);

      // add overflow with response backpressure
      bus1.rsp_ready = 1'b0;
      send1(3'b000, 8'hFF, 8'h01, 1'b0, lat);
      chk("ovf_latency", 32'(lat), 32'd2);
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 32'(bus1.rsp_valid), 32'h1);
         chk("bp_data",  32'(bus1.rsp_data),  32'h00);
         chk("bp_carry", 32'(bus1.rsp_carry), 32'h1);
         chk("bp_ready", 32'(bus1.cmd_ready), 32'h0);
         tick();
      end
      bus1.rsp_ready = 1'b1;
      tick();
      chk("ovf_ready", 32'(bus1.cmd_ready), 32'h1);
      chk("ovf_count", 32'(cnt1),           32'd4);
      chk("ovf_acc",   32'(acc1),           32'h00);

      // not of accumulator (00 -> FF)
      send1(3'b100, 8'h12, 8'h34, 1'b1, lat);
      chk("not_data",  32'(bus1.rsp_data),  32'hFF);
      chk("not_carry", 32'(bus1.rsp_carry), 32'h0);
      tick();

      // or
      send1(3'b011, 8'h50, 8'h0A, 1'b0, lat);
      chk("or_data", 32'(bus1.rsp_data), 32'h5A);
      tick();
      chk("or_count", 32'(cnt1), 32'd6);

      // SETTLE_CYCLES=4 instance
      send4(8'h03, 8'h04, lat);
      chk("s4_latency", 32'(lat),           32'd5);
      chk("s4_data",    32'(bus4.rsp_data), 32'h07);
      tick();
      chk("s4_count",   32'(cnt4),          32'd1);

      // reset mid-DRIVE abandons the operation
      bus4.cmd_op    = 3'b000;
      bus4.cmd_a     = 8'h10;
      bus4.cmd_b     = 8'h20;
      bus4.cmd_valid = 1'b1;
      tick();
      bus4.cmd_valid = 1'b0;
      tick();
      chk("s4_drive_vld", 32'(bus4.rsp_valid), 32'h0);
      rst4 = 1'b1;
      tick();
      chk("s4rst_valid", 32'(bus4.rsp_valid), 32'h0);
      chk("s4rst_ready", 32'(bus4.cmd_ready), 32'h0);
      chk("s4rst_alu_a", 32'(a4),             32'h0);
      chk("s4rst_alu_b", 32'(b4),             32'h0);
      chk("s4rst_acc",   32'(acc4),           32'h0);
      chk("s4rst_count", 32'(cnt4),           32'h0);
      chk("s4rst_data",  32'(bus4.rsp_data),  32'h0);
      rst4 = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus4.rsp_valid) seen = 1'b1;
      end
      chk("s4rst_no_rsp", 32'(seen), 32'h0);
      send4(8'h10, 8'h20, lat);
      chk("s4_after_lat",  32'(lat),           32'd5);
      chk("s4_after_data", 32'(bus4.rsp_data), 32'h30);
      tick();
      chk("s4_after_cnt",  32'(cnt4),          32'd1);
      chk("s4_after_acc",  32'(acc4),          32'h30);

`ifdef ALU_SEQ_CHECK_EN
      chk("chk_clean", 32'(chk1), 32'h0);
      force_zero = 1'b1;
      send1(3'b000, 8'h01, 8'h09, 1'b0, lat);
      chk("chk_forced_data", 32'(bus1.rsp_data), 32'h00);
      chk("chk_set",         32'(chk1),          32'h1);
      tick();
      force_zero = 1'b0;
      send1(3'b000, 8'h02, 8'h03, 1'b0, lat);
      chk("chk_good_data",   32'(bus1.rsp_data), 32'h05);
      tick();
      chk("chk_sticky",      32'(chk1),          32'h1);
      chk("chk4_clean",      32'(chk4),          32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
